// File: rtl/jtag_cmd_sched_pkg.sv
// Shared types and constants for the JTAG command scheduler.
// Command codes, FSM states and the TAP reset pattern length.
package jtag_sched_pkg;

    typedef enum logic [2:0] {
        CMD_RESET               = 3'd0,
        CMD_TMS_SEQ             = 3'd1,
        CMD_SCAN_CHAIN          = 3'd2,
        CMD_SCAN_CHAIN_FLIP_TMS = 3'd3
    } jtag_cmd_e;

    typedef enum logic [2:0] {
        StIdle,
        StGrant,
        StRstSeq,
        StFetch,
        StLow,
        StHigh,
        StPush,
        StFin
    } sched_state_e;

    localparam int unsigned RESET_TMS_ONES = 5;

    function automatic logic cmd_is_scan(logic [2:0] cmd);
        return (cmd == CMD_SCAN_CHAIN) || (cmd == CMD_SCAN_CHAIN_FLIP_TMS);
    endfunction

endpackage

// File: rtl/jtag_cmd_sched_if.sv
// Requester-side bus of the JTAG command scheduler: command, source-byte and
// captured-byte handshakes for all requesters, plus the per-requester done pulse.
interface jtag_cmd_sched_if #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned NB_W = 16
);
    logic [NREQ-1:0]           req_valid;
    logic [NREQ-1:0][2:0]      req_cmd;
    logic [NREQ-1:0][NB_W-1:0] req_nbits;
    logic [NREQ-1:0]           req_ready;
    logic [NREQ-1:0][7:0]      din_byte;
    logic [NREQ-1:0]           din_valid;
    logic [NREQ-1:0]           din_ready;
    logic [7:0]                dout_byte;
    logic [NREQ-1:0]           dout_valid;
    logic [NREQ-1:0]           dout_ready;
    logic [NREQ-1:0]           done;

    modport master (
        output req_valid, req_cmd, req_nbits, din_byte, din_valid, dout_ready,
        input  req_ready, din_ready, dout_byte, dout_valid, done
    );

    modport slave (
        input  req_valid, req_cmd, req_nbits, din_byte, din_valid, dout_ready,
        output req_ready, din_ready, dout_byte, dout_valid, done
    );
endinterface

// File: rtl/jtag_rr_arbiter.sv
// Round-robin arbiter: the first requester at or after the pointer wins;
// the pointer moves past the winner when the grant is accepted.
module jtag_rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IdxW = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_i,
    input  logic            accept_i,
    output logic [IdxW-1:0] gnt_idx_o,
    output logic            gnt_valid_o
);
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] lo_idx, hi_idx;
    logic            lo_hit, hi_hit;

    // Descending scan leaves the lowest index; hi_* only considers indices >= pointer.
    always_comb begin
        lo_hit = 1'b0;
        hi_hit = 1'b0;
        lo_idx = '0;
        hi_idx = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (req_i[IdxW'(i)]) begin
                lo_hit = 1'b1;
                lo_idx = IdxW'(i);
                if (IdxW'(i) >= ptr_q) begin
                    hi_hit = 1'b1;
                    hi_idx = IdxW'(i);
                end
            end
        end
        gnt_valid_o = lo_hit;
        gnt_idx_o   = hi_hit ? hi_idx : lo_idx;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept_i && gnt_valid_o) begin
            ptr_d = (gnt_idx_o == IdxW'(NREQ - 1)) ? '0 : gnt_idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
endmodule

// File: rtl/jtag_cmd_sched.sv
// JTAG command scheduler: shares one TAP between requesters, runs RESET/TMS/SCAN
// commands bit by bit LSB-first and returns captured TDO bytes to the owner.
module jtag_cmd_sched
    import jtag_sched_pkg::*;
#(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned TCK_DIV = 4,
    parameter int unsigned NB_W    = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable_i,
    jtag_cmd_sched_if.slave bus,
    output logic            err_o,
    output logic            busy_o,
    output logic            tck_o,
    output logic            tms_o,
    output logic            tdi_o,
    input  logic            tdo_i
);
    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned DivW = $clog2(TCK_DIV + 1);

    sched_state_e    state_q, state_d;
    logic [IdxW-1:0] owner_q, owner_d;
    logic [2:0]      cmd_q, cmd_d;
    logic [NB_W-1:0] bits_q, bits_d;
    logic [2:0]      bidx_q, bidx_d;
    logic [7:0]      din_q, din_d;
    logic [7:0]      dout_q, dout_d;
    logic [DivW-1:0] div_q, div_d;
    logic            tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d, err_q, err_d;
    logic [7:0]      src_byte;
    logic            drv_bit;
    logic [IdxW-1:0] arb_idx;
    logic            arb_valid, arb_accept;

    assign arb_accept = (state_q == StIdle) && enable_i;

    jtag_rr_arbiter #(
        .NREQ (NREQ),
        .IdxW (IdxW)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (bus.req_valid),
        .accept_i    (arb_accept),
        .gnt_idx_o   (arb_idx),
        .gnt_valid_o (arb_valid)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        cmd_d    = cmd_q;
        bits_d   = bits_q;
        bidx_d   = bidx_q;
        din_d    = din_q;
        dout_d   = dout_q;
        div_d    = div_q;
        tck_d    = tck_q;
        tms_d    = tms_q;
        tdi_d    = tdi_q;
        err_d    = err_q;
        src_byte = din_q;
        drv_bit  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (arb_accept && arb_valid) begin
                    owner_d = arb_idx;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                cmd_d  = bus.req_cmd[owner_q];
                bits_d = bus.req_nbits[owner_q];
                bidx_d = '0;
                dout_d = '0;
                div_d  = '0;
                err_d  = (bus.req_cmd[owner_q] > 3'd3);
                if (err_d)                    state_d = StFin;
                else if (cmd_d == CMD_RESET)  state_d = StRstSeq;
                else if (bits_d == '0)        state_d = StFin;
                else                          state_d = StFetch;
            end
            StRstSeq: begin
                // Reset walks the TMS path like a 6-bit TMS sequence: five ones, then a zero.
                bits_d   = NB_W'(RESET_TMS_ONES + 1);
                din_d    = 8'((1 << RESET_TMS_ONES) - 1);
                src_byte = din_d;
                state_d  = StLow;
            end
            StFetch: begin
                src_byte = bus.din_byte[owner_q];
                if (bus.din_valid[owner_q]) begin
                    din_d   = src_byte;
                    state_d = StLow;
                end
            end
            StLow: begin
                if (div_q == DivW'(TCK_DIV - 1)) begin
                    div_d   = '0;
                    tck_d   = 1'b1;
                    state_d = StHigh;
                    if (cmd_is_scan(cmd_q)) dout_d[bidx_q] = tdo_i;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StHigh: begin
                if (div_q == DivW'(TCK_DIV - 1)) begin
                    div_d  = '0;
                    tck_d  = 1'b0;
                    bits_d = bits_q - 1'b1;
                    bidx_d = bidx_q + 3'd1;
                    if (bits_q == NB_W'(1) || bidx_q == 3'd7) begin
                        if (cmd_is_scan(cmd_q))      state_d = StPush;
                        else if (bits_q == NB_W'(1)) state_d = StFin;
                        else                         state_d = StFetch;
                    end else begin
                        state_d = StLow;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StPush: begin
                if (bus.dout_ready[owner_q]) begin
                    dout_d  = '0;
                    state_d = (bits_q == '0) ? StFin : StFetch;
                end
            end
            StFin: begin
                err_d   = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Pins change only on entry to the low phase, so they are stable at the rising edge.
        if (state_d == StLow && state_q != StLow) begin
            drv_bit = src_byte[bidx_d];
            if (cmd_is_scan(cmd_q)) begin
                tdi_d = drv_bit;
                tms_d = (cmd_q == CMD_SCAN_CHAIN_FLIP_TMS) && (bits_d == NB_W'(1));
            end else begin
                tms_d = drv_bit;
            end
        end
        if (state_d == StFin) begin
            tck_d = 1'b0;
            tms_d = 1'b0;
            tdi_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            owner_q <= '0;
            cmd_q   <= '0;
            bits_q  <= '0;
            bidx_q  <= '0;
            din_q   <= '0;
            dout_q  <= '0;
            div_q   <= '0;
            tck_q   <= 1'b0;
            tms_q   <= 1'b0;
            tdi_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cmd_q   <= cmd_d;
            bits_q  <= bits_d;
            bidx_q  <= bidx_d;
            din_q   <= din_d;
            dout_q  <= dout_d;
            div_q   <= div_d;
            tck_q   <= tck_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        bus.req_ready  = '0;
        bus.din_ready  = '0;
        bus.dout_valid = '0;
        bus.done       = '0;
        if (state_q == StGrant)                             bus.req_ready[owner_q]  = 1'b1;
        if (state_q == StFetch && bus.din_valid[owner_q])   bus.din_ready[owner_q]  = 1'b1;
        if (state_q == StPush)                              bus.dout_valid[owner_q] = 1'b1;
        if (state_q == StFin)                               bus.done[owner_q]       = 1'b1;
    end

    assign bus.dout_byte = dout_q;
    assign err_o         = (state_q == StFin) && err_q;
    assign busy_o        = (state_q != StIdle);
    assign tck_o         = tck_q;
    assign tms_o         = tms_q;
    assign tdi_o         = tdi_q;
endmodule

// File: tb/tb_jtag_cmd_sched.sv
// Randomized self-checking bench for jtag_cmd_sched: pin sequences, returned
// bytes, done/err and arbitration are compared against a command-level model.
module tb_jtag_cmd_sched;
    localparam int NREQ    = 2;
    localparam int TCK_DIV = 2;
    localparam int NB_W    = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic enable;
    logic err, busy, tck, tms, tdi, tdo;
    logic tdo_inv;

    jtag_cmd_sched_if #(.NREQ(NREQ), .NB_W(NB_W)) bus ();

    jtag_cmd_sched #(
        .NREQ    (NREQ),
        .TCK_DIV (TCK_DIV),
        .NB_W    (NB_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable_i (enable),
        .bus      (bus),
        .err_o    (err),
        .busy_o   (busy),
        .tck_o    (tck),
        .tms_o    (tms),
        .tdi_o    (tdi),
        .tdo_i    (tdo)
    );

    always #5 clk = ~clk;
    assign tdo = tdi ^ tdo_inv;

    int n_checks = 0;
    int n_pass   = 0;
    int rr_ptr   = 0;
    logic [7:0] tx_data [8];

    // Pin monitor: cumulative, snapshotted by each command.
    logic mon_tms [$];
    logic mon_tdi [$];
    logic tck_prev = 1'b0;
    int   run_len = 0;
    int   high_bad = 0;
    int   low_bad = 0;
    int   tck_in_push = 0;

    always @(negedge clk) begin
        if (tck && !tck_prev) begin
            mon_tms.push_back(tms);
            mon_tdi.push_back(tdi);
        end
        if (tck == tck_prev) begin
            run_len++;
        end else begin
            if (tck_prev && run_len != TCK_DIV) high_bad++;
            if (!tck_prev && run_len < TCK_DIV) low_bad++;
            run_len = 1;
        end
        if (bus.dout_valid != '0 && tck) tck_in_push++;
        tck_prev = tck;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [63:0] data_bits(input int nbits);
        logic [63:0] v;
        for (int k = 0; k < 8; k++) v[k*8 +: 8] = tx_data[k];
        return (nbits >= 64) ? v : (v & ((64'd1 << nbits) - 64'd1));
    endfunction

    task automatic idle_inputs();
        bus.req_valid  = '0;
        bus.din_valid  = '0;
        bus.dout_ready = '0;
    endtask

    // Issues one command from requester r and checks everything it produced.
    task automatic run_cmd(input string name, input int r, input logic [2:0] cmd, input int nbits,
                           input logic inv, input int first_stall, input int max_stall);
        logic        rx, ox, granted, got_done, got_err, stray;
        int          nbytes, di, stall, gap, s_edge, s_high, s_low, s_push, n_edge;
        int          exp_edges, exp_nout;
        logic [7:0]  got_out [$];
        logic [63:0] got_tms, got_tdi, exp_tms, exp_tdi;
        logic [7:0]  exp_b;
        rx = r[0];
        ox = ~rx;
        nbytes = (nbits + 7) / 8;
        @(negedge clk);
        tdo_inv = inv;
        s_edge = mon_tms.size();
        s_high = high_bad; s_low = low_bad; s_push = tck_in_push;
        bus.req_valid[rx] = 1'b1;
        bus.req_cmd[rx]   = cmd;
        bus.req_nbits[rx] = NB_W'(nbits);
        granted = 1'b0; got_done = 1'b0; got_err = 1'b0; stray = 1'b0;
        di = 0; stall = first_stall; gap = 0;
        for (int cyc = 0; cyc < 6000 && !got_done; cyc++) begin
            if (cyc > 0) @(negedge clk);
            bus.din_valid[ox]  = 1'($urandom_range(0, 1));
            bus.din_byte[ox]   = 8'($urandom);
            bus.dout_ready[ox] = 1'($urandom_range(0, 1));
            bus.din_valid[rx]  = (di < nbytes) && (gap == 0);
            bus.din_byte[rx]   = (di < 8) ? tx_data[di] : 8'h00;
            bus.dout_ready[rx] = (stall == 0);
            if (granted) enable = 1'($urandom_range(0, 1));
            #1;
            if (bus.req_ready[ox] || bus.din_ready[ox] || bus.dout_valid[ox] || bus.done[ox])
                stray = 1'b1;
            if (bus.req_ready[rx]) begin
                granted = 1'b1;
                bus.req_valid[rx] = 1'b0;
                rr_ptr = (r + 1) % NREQ;
            end
            if (bus.din_ready[rx]) begin
                di++;
                gap = $urandom_range(0, max_stall);
            end else if (gap > 0) begin
                gap--;
            end
            if (bus.dout_valid[rx]) begin
                if (bus.dout_ready[rx]) begin
                    got_out.push_back(bus.dout_byte);
                    stall = $urandom_range(0, max_stall);
                end else if (stall > 0) begin
                    stall--;
                end
            end
            if (bus.done[rx]) begin
                got_done = 1'b1;
                got_err  = err;
            end
        end
        @(negedge clk);
        enable = 1'b1;
        idle_inputs();
        #1;
        check({name, " done"}, 64'(got_done), 64'd1);
        check({name, " busy after done"}, 64'(busy), 64'd0);

        // Command-level model.
        exp_tms = '0; exp_tdi = '0; exp_edges = 0; exp_nout = 0;
        if (cmd > 3'd3) begin
            exp_edges = 0;
        end else if (cmd == 3'd0) begin
            exp_edges = 6;
            exp_tms   = 64'h1F;
        end else if (nbits > 0) begin
            exp_edges = nbits;
            if (cmd == 3'd1) begin
                exp_tms = data_bits(nbits);
            end else begin
                exp_tdi  = data_bits(nbits);
                exp_nout = nbytes;
                if (cmd == 3'd3) exp_tms = 64'd1 << (nbits - 1);
            end
        end
        n_edge  = mon_tms.size() - s_edge;
        got_tms = '0; got_tdi = '0;
        for (int k = 0; k < n_edge && k < 64; k++) begin
            got_tms[k] = mon_tms[s_edge + k];
            got_tdi[k] = mon_tdi[s_edge + k];
        end
        check({name, " err"}, 64'(got_err), 64'(cmd > 3'd3));
        check({name, " tck edges"}, 64'(n_edge), 64'(exp_edges));
        check({name, " tms at edges"}, got_tms, exp_tms);
        check({name, " tdi at edges"}, got_tdi, exp_tdi);
        check({name, " dout count"}, 64'(got_out.size()), 64'(exp_nout));
        for (int j = 0; j < exp_nout && j < got_out.size(); j++) begin
            exp_b = tx_data[j] ^ {8{inv}};
            if (j == exp_nout - 1 && (nbits % 8) != 0) exp_b = exp_b & 8'((1 << (nbits % 8)) - 1);
            check($sformatf("%s dout%0d", name, j), 64'(got_out[j]), 64'(exp_b));
        end
        check({name, " non-owner quiet"}, 64'(stray), 64'd0);
        check({name, " tck high width"}, 64'(high_bad - s_high), 64'd0);
        check({name, " tck low width"}, 64'(low_bad - s_low), 64'd0);
        check({name, " tck low in push"}, 64'(tck_in_push - s_push), 64'd0);
    endtask

    // Both requesters ask at once; grant order must follow the round-robin pointer.
    task automatic arb_round(input string name);
        int  order [$];
        int  exp0, exp1;
        logic timed_out;
        exp0 = rr_ptr;
        exp1 = (rr_ptr + 1) % NREQ;
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i]  = 1'b1;
            bus.req_cmd[i]    = 3'd1;
            bus.req_nbits[i]  = NB_W'(3);
            bus.din_byte[i]   = 8'h05;
            bus.din_valid[i]  = 1'b1;
            bus.dout_ready[i] = 1'b1;
        end
        timed_out = 1'b1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_ready[i]) begin
                    order.push_back(i);
                    bus.req_valid[i] = 1'b0;
                end
            end
            if (order.size() == 2 && !busy) begin
                timed_out = 1'b0;
                break;
            end
        end
        idle_inputs();
        rr_ptr = (exp1 + 1) % NREQ;
        check({name, " finished"}, 64'(timed_out), 64'd0);
        check({name, " first grant"}, 64'(order.size() > 0 ? order[0] : -1), 64'(exp0));
        check({name, " second grant"}, 64'(order.size() > 1 ? order[1] : -1), 64'(exp1));
    endtask

    initial begin
        logic [2:0] rcmd;
        int         pick;
        rst_n = 1'b0;
        enable = 1'b1;
        tdo_inv = 1'b0;
        bus.req_cmd   = '0;
        bus.req_nbits = '0;
        bus.din_byte  = '0;
        idle_inputs();
        repeat (3) @(negedge clk);
        check("reset outputs (in reset)",
              64'({tck, tms, tdi, busy, err, bus.req_ready, bus.din_ready, bus.dout_valid, bus.done}),
              64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("reset outputs (after release)",
              64'({tck, tms, tdi, busy, err, bus.req_ready, bus.din_ready, bus.dout_valid, bus.done}),
              64'd0);

        run_cmd("reset_cmd", 0, 3'd0, 0, 1'b0, 0, 0);
        tx_data[0] = 8'hA5; tx_data[1] = 8'h03;
        run_cmd("scan12", 0, 3'd2, 12, 1'b0, 0, 0);
        tx_data[0] = 8'h6B;
        run_cmd("flip8", 1, 3'd3, 8, 1'b0, 0, 0);
        tx_data[0] = 8'hC3; tx_data[1] = 8'h5A;
        run_cmd("scan16_stall", 0, 3'd2, 16, 1'b1, 50, 0);
        run_cmd("illegal5", 1, 3'd5, 9, 1'b0, 0, 0);
        run_cmd("scan_zero", 0, 3'd2, 0, 1'b0, 0, 0);
        tx_data[0] = 8'h96; tx_data[1] = 8'h01;
        run_cmd("tms10", 1, 3'd1, 10, 1'b0, 0, 2);

        // No grant while disabled.
        @(negedge clk);
        enable = 1'b0;
        bus.req_valid[1] = 1'b1;
        bus.req_cmd[1]   = 3'd1;
        bus.req_nbits[1] = NB_W'(4);
        pick = 0;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (busy || bus.req_ready != '0) pick = 1;
        end
        check("no grant while disabled", 64'(pick), 64'd0);
        bus.req_valid[1] = 1'b0;
        enable = 1'b1;

        // Reset in the middle of a scan.
        @(negedge clk);
        bus.req_valid[0]  = 1'b1;
        bus.req_cmd[0]    = 3'd2;
        bus.req_nbits[0]  = NB_W'(16);
        bus.din_byte[0]   = 8'h3C;
        bus.din_valid[0]  = 1'b1;
        bus.dout_ready[0] = 1'b0;
        repeat (12) @(negedge clk);
        bus.req_valid[0] = 1'b0;
        #1;
        check("mid-scan busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid-scan reset outputs",
              64'({tck, tms, tdi, busy, err, bus.req_ready, bus.din_ready, bus.dout_valid, bus.done}),
              64'd0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        rr_ptr = 0;
        repeat (2) @(negedge clk);

        arb_round("arb round1");
        arb_round("arb round2");

        for (int n = 0; n < 24; n++) begin
            pick = $urandom_range(0, 10);
            if (pick < 2)      rcmd = 3'd0;
            else if (pick < 4) rcmd = 3'd1;
            else if (pick < 7) rcmd = 3'd2;
            else if (pick < 9) rcmd = 3'd3;
            else               rcmd = 3'($urandom_range(4, 7));
            for (int k = 0; k < 8; k++) tx_data[k] = 8'($urandom);
            run_cmd($sformatf("rnd%0d", n), $urandom_range(0, 1), rcmd, $urandom_range(0, 40),
                    1'($urandom_range(0, 1)), $urandom_range(0, 3), 3);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
